// File: rtl/aes128_decrypt_iter_pkg.sv
// Shared definitions for the iterative AES-128 decryptor: FSM encoding, round count,
// Rcon table and the forward/inverse S-box lookups.
package aes128_decrypt_iter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StRound,
        StDone
    } state_e;

    localparam int unsigned NR = 10;

    // Rcon for rounds 1..10, round 1 in the top byte
    localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            r = RCON_TBL[8 * (10 - int'(idx)) +: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[8 * (255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[8 * (255 - int'(b)) +: 8];
    endfunction

endpackage

// File: rtl/aes128_decrypt_iter_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless this is the final round, InvMixColumns.
module aes_inv_round
    import aes128_decrypt_iter_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_round_i,
    output logic [127:0] state_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        // Byte r+4c sits at row r, column c; row r rotates right by r columns
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(r+4*c) -: 8] = state_i[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        for (int i = 0; i < 16; i++) begin
            subbed[127-8*i -: 8] = inv_sbox(shifted[127-8*i -: 8]);
        end
        keyed = subbed ^ round_key_i;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_col(keyed[127-32*c -: 32]);
        end
        state_o = last_round_i ? keyed : mixed;
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key schedule forward, then runs one inverse
// round per clock. Optionally skips expansion when the key matches the last one.
module aes128_decrypt_iter
    import aes128_decrypt_iter_pkg::*;
#(
    parameter int unsigned KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_text,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_text,
    output logic         busy
);

    function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] rk_q [NR+1];
    logic         cache_vld_q, cache_vld_d;
    logic         init_q;

    logic         rk_we;
    logic [3:0]   rk_widx;
    logic [127:0] rk_wdata;
    logic [3:0]   prev_idx;
    logic [127:0] next_rk;
    logic [127:0] round_key;
    logic [127:0] round_out;
    logic         accept;
    logic         cache_hit;

    assign prev_idx  = cnt_q - 4'd1;
    assign next_rk   = key_step(rk_q[prev_idx], rcon(cnt_q));
    assign round_key = rk_q[cnt_q];
    assign accept    = in_valid && in_ready;
    assign cache_hit = (KEY_CACHE != 0) && cache_vld_q && (key == rk_q[0]);

    aes_inv_round u_inv_round (
        .state_i      (blk_q),
        .round_key_i  (round_key),
        .last_round_i (cnt_q == 4'd0),
        .state_o      (round_out)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        cache_vld_d = cache_vld_q;
        rk_we       = 1'b0;
        rk_widx     = cnt_q;
        rk_wdata    = next_rk;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cache_hit) begin
                        blk_d   = cipher_text ^ rk_q[NR];
                        cnt_d   = 4'(NR - 1);
                        state_d = StRound;
                    end else begin
                        rk_we       = 1'b1;
                        rk_widx     = 4'd0;
                        rk_wdata    = key;
                        blk_d       = cipher_text;
                        cnt_d       = 4'd1;
                        // The schedule is about to be overwritten
                        cache_vld_d = 1'b0;
                        state_d     = StExpand;
                    end
                end
            end
            StExpand: begin
                rk_we = 1'b1;
                if (cnt_q == 4'(NR)) begin
                    blk_d       = blk_q ^ next_rk;
                    cnt_d       = 4'(NR - 1);
                    cache_vld_d = 1'b1;
                    state_d     = StRound;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRound: begin
                blk_d = round_out;
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            blk_q       <= '0;
            cache_vld_q <= 1'b0;
            init_q      <= 1'b0;
            for (int unsigned i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            cache_vld_q <= cache_vld_d;
            init_q      <= 1'b1;
            if (rk_we) begin
                rk_q[rk_widx] <= rk_wdata;
            end
        end
    end

    // init_q keeps in_ready low while reset is asserted, even though the FSM sits in idle
    assign in_ready   = init_q && (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign plain_text = out_valid ? blk_q : '0;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed bench for aes128_decrypt_iter using FIPS-197 vectors, one cached and one
// uncached instance.
module tb_aes128_decrypt_iter;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_valid_nc = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_ready_nc = 1'b0;
    logic [127:0] cipher_text = '0;
    logic [127:0] key = '0;
    logic         in_ready, out_valid, busy;
    logic         in_ready_nc, out_valid_nc, busy_nc;
    logic [127:0] plain_text, plain_text_nc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    aes128_decrypt_iter #(.KEY_CACHE(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cipher_text (cipher_text),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .plain_text  (plain_text),
        .busy        (busy)
    );

    aes128_decrypt_iter #(.KEY_CACHE(0)) dut_nc (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid_nc),
        .in_ready    (in_ready_nc),
        .cipher_text (cipher_text),
        .key         (key),
        .out_valid   (out_valid_nc),
        .out_ready   (out_ready_nc),
        .plain_text  (plain_text_nc),
        .busy        (busy_nc)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Submit one request, measure latency, optionally stall the output, then complete it
    task automatic request(input bit nc, input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input int exp_lat, input int hold,
                           input bit churn, input string tag);
        int lat;
        @(negedge clk);
        key         = k;
        cipher_text = ct;
        if (nc) in_valid_nc = 1'b1;
        else    in_valid    = 1'b1;
        check({tag, " in_ready before"}, nc ? in_ready_nc : in_ready, 128'd1);
        @(posedge clk);
        #1;
        if (!churn) begin
            in_valid    = 1'b0;
            in_valid_nc = 1'b0;
        end
        lat = 1;
        while (!(nc ? out_valid_nc : out_valid) && lat < 40) begin
            if (churn) cipher_text = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid    = 1'b0;
        in_valid_nc = 1'b0;
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " plain_text"}, nc ? plain_text_nc : plain_text, exp_pt);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " held out_valid"}, out_valid, 128'd1);
            check({tag, " held plain_text"}, plain_text, exp_pt);
            check({tag, " held in_ready"}, in_ready, 128'd0);
        end
        if (nc) out_ready_nc = 1'b1;
        else    out_ready    = 1'b1;
        @(posedge clk);
        #1;
        out_ready    = 1'b0;
        out_ready_nc = 1'b0;
        check({tag, " in_ready after"}, nc ? in_ready_nc : in_ready, 128'd1);
        check({tag, " out_valid after"}, nc ? out_valid_nc : out_valid, 128'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 128'd0);
        check("reset out_valid", out_valid, 128'd0);
        check("reset plain_text", plain_text, 128'd0);
        check("reset busy", busy, 128'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first edge in_ready", in_ready, 128'd1);

        request(1'b0, KEY1, CT1, PT1, 21, 0, 1'b0, "c1_miss");
        request(1'b0, KEY2, CT2, PT2, 21, 0, 1'b0, "b_miss");
        request(1'b0, KEY2, CT2, PT2, 11, 0, 1'b0, "b_hit");
        request(1'b0, KEY2, CT2, PT2, 11, 5, 1'b0, "stall");
        request(1'b0, KEY1, CT1, PT1, 21, 0, 1'b1, "churn_miss");
        request(1'b0, KEY1, CT1, PT1, 11, 0, 1'b1, "churn_hit");

        // Reset during the 7th expansion cycle of a miss
        @(negedge clk);
        key         = KEY2;
        cipher_text = CT2;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid expand busy", busy, 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", in_ready, 128'd0);
        check("abort out_valid", out_valid, 128'd0);
        check("abort plain_text", plain_text, 128'd0);
        check("abort busy", busy, 128'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        request(1'b0, KEY2, CT2, PT2, 21, 0, 1'b0, "after_abort");

        // Reset while idle must also drop a valid cache entry
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        request(1'b0, KEY2, CT2, PT2, 21, 0, 1'b0, "idle_reset");

        request(1'b1, KEY1, CT1, PT1, 21, 0, 1'b0, "nocache_1");
        request(1'b1, KEY1, CT1, PT1, 21, 0, 1'b0, "nocache_2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes128_decrypt_iter.md
AES128_DECRYPT_ITER -- requirements
Module: aes128_decrypt_iter

Interface
REQ-001 SHALL have parameter KEY_CACHE, default 1; 1 = skip key expansion when the new key equals the last fully expanded key.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, cipher_text/key valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 SHALL have port cipher_text, input, 128, ciphertext block, byte 0 in bits [127:120].
REQ-007 SHALL have port key, input, 128, AES-128 cipher key (round key 0), same byte order.
REQ-008 SHALL have port out_valid, output, 1, plain_text valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts plain_text.
REQ-010 SHALL have port plain_text, output, 128, decrypted block.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement the FIPS-197 AES-128 inverse cipher, one round per clock.
REQ-013 SHALL use FSM states IDLE, EXPAND, ROUND, DONE; in_ready = (state == IDLE).
REQ-014 Acceptance SHALL be in_valid && in_ready at a rising edge; inputs are sampled only then, and later input changes are ignored.
REQ-015 On acceptance, on a cache miss, or when KEY_CACHE = 0: rk[0] <= key, hold cipher_text, cnt <= 1, go to EXPAND.
REQ-016 In EXPAND, each cycle SHALL compute rk[cnt] from rk[cnt-1] (RotWord, SubWord, Rcon[cnt]) and increment cnt.
REQ-017 When cnt = 10, EXPAND SHALL store rk[10], set state <= cipher ^ rk[10], set cnt <= 9, and go to ROUND.
REQ-018 On acceptance with a cache hit, the block SHALL set state <= cipher_text ^ rk[10], set cnt <= 9, and go directly to ROUND.
REQ-019 In ROUND with cnt in 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[cnt]); cnt decrements.
REQ-020 In ROUND with cnt = 0: state <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; go to DONE.
REQ-021 Latency from the acceptance edge to the first cycle with out_valid high SHALL be 21 cycles on a miss and 11 cycles on a hit.
REQ-022 In DONE, out_valid SHALL be 1 and plain_text SHALL hold stable until out_ready is seen high at an edge, then go to IDLE.
REQ-023 out_valid high with out_ready high in the same cycle SHALL complete the transfer; in_ready rises the next cycle, with no overlap of input and output transfers.
REQ-024 A key-cache valid flag SHALL be set only when EXPAND completes; cache hit = flag && (key == rk[0]).
REQ-025 plain_text SHALL be driven from the state register only (registered output), and SHALL read 0 outside DONE.
REQ-026 Rcon SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.

Reset
REQ-027 rst_n low SHALL, asynchronously, force state = IDLE, cnt = 0, the state register to 0, all rk entries to 0, and the cache flag to 0.
REQ-028 During reset, outputs SHALL be in_ready = 0, out_valid = 0, plain_text = 0, and busy = 0.
REQ-029 After release, the block SHALL drive in_ready = 1 from the first clock edge.
REQ-030 Reset mid-operation SHALL abandon the block with no output, and SHALL invalidate the cache so that the next request always runs EXPAND.

Structure
REQ-031 The shared package/include SHALL hold the FSM state encodings, NR = 10, the Rcon table, and the S-box and inverse S-box functions.
REQ-032 There SHALL be one sub-module, aes_inv_round: combinational InvShiftRows, InvSubBytes, optional InvMixColumns (last_round input), and AddRoundKey.
REQ-033 Round-key storage SHALL be 11 x 128-bit registers; there is no RAM.

Verification
REQ-034 Key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> plain 00112233445566778899aabbccddeeff, out_valid 21 cycles after acceptance.
REQ-035 Same key, then key 2b7e151628aed2a6abf7158809cf4f3c with cipher 3925841d02dc09fbdc118597196a0b32 -> plain 3243f6a8885a308d313198a2e0370734 at 21 cycles; a repeat of that request -> same plain at 11 cycles (hit).
REQ-036 out_ready held low for 5 cycles in DONE -> plain_text and out_valid stable, in_ready = 0 throughout; out_ready pulse -> in_ready = 1 next cycle.
REQ-037 rst_n pulsed low at cycle 7 of EXPAND -> outputs go to their reset values immediately; the same request resubmitted -> correct plain at 21 cycles (cache invalid).
REQ-038 in_valid held high with changing cipher_text while busy -> no acceptance; the result matches the first sampled input.
REQ-039 KEY_CACHE = 0 with a repeated key -> latency 21 cycles every time.
